// File: rtl/buffer_arbiter_pkg.sv
// Shared types and constants for the buffer arbiter slice.
package buffer_arbiter_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int NUM_BITS_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first valid at or above ptr, wrapping.
module rr_select
  import buffer_arbiter_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  // Walk offsets high to low so the nearest offset from ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter feeding one shared holding register.
// BUFFER_ARBITER_PIPE_EN: regrant in the same cycle the held word drains.
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEF,
  parameter  int NUM_BITS = NUM_BITS_DEF,
  localparam int IW       = idx_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [NUM_BITS-1:0]          out_data,
  input  logic                         out_ready,
  output logic [IW-1:0]                grant_id,
  output logic                         busy
);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       win;
  logic                any;
  logic                slot_open;
  logic                take;
  logic [NUM_BITS-1:0] sel_data;
  logic [IW-1:0]       nxt_ptr;

  rr_select #(
    .N (NUM_REQ),
    .W (IW)
  ) u_sel (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

`ifdef BUFFER_ARBITER_PIPE_EN
  assign slot_open = (state == IDLE) || out_ready;
`else
  assign slot_open = (state == IDLE);
`endif

  assign take      = n_rst && slot_open && any;
  assign req_ready = take ? grant : '0;
  assign nxt_ptr   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data |= req_data[i*NUM_BITS +: NUM_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      out_data <= '0;
      grant_id <= '0;
    end else if (take) begin
      state    <= HOLD;
      ptr      <= nxt_ptr;
      out_data <= sel_data;
      grant_id <= win;
    end else if (state == HOLD && out_ready) begin
      state <= IDLE;
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = out_valid;

endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Round-robin arbiter that shares one registered holding stage of NUM_BITS width among NUM_REQ requesters. Requesters present data with a valid/ready handshake. The winner's word is captured into the holding register and presented downstream with valid/ready until it is consumed. The block sits between producer blocks and a single shared downstream consumer, and sequences which producer owns the register stage in each slot.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- NUM_BITS, 32, data word width
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  reset; synchronous, active-low
- req_valid  input  NUM_REQ  per-requester data valid; requester holds valid and data until its req_ready is seen
- req_data  input  NUM_REQ*NUM_BITS  packed request words; requester i occupies bits [i*NUM_BITS +: NUM_BITS]
- req_ready  output  NUM_REQ  one-hot (or zero) combinational grant; transfer occurs when req_valid[i] & req_ready[i]
- out_valid  output  1  holding register contains an unconsumed word
- out_data  output  NUM_BITS  holding register contents
- out_ready  input  1  downstream accepts the word this cycle when out_valid=1
- grant_id  output  $clog2(NUM_REQ)  index of the requester whose word is in out_data
- busy  output  1  equals out_valid; provided for status logic

## Operation
- State machine: IDLE (register empty) and HOLD (register full).
- Round-robin pointer ptr (width of grant_id). The winner is the first i with req_valid[i]=1 when searching from ptr upward, wrapping NUM_REQ-1 -> 0.
- IDLE: if any req_valid, req_ready[winner]=1. On the clock edge, out_data<=req_data[winner], grant_id<=winner, ptr<=winner+1 (mod NUM_REQ), state->HOLD. If no req_valid, req_ready=0 and state and ptr are unchanged.
- HOLD: out_valid=1. out_data and grant_id are stable regardless of req_* activity. If out_ready=0, the block stays in HOLD and req_ready=0. If out_ready=1, behaviour follows Configuration.
- Requesters that are not granted see req_ready=0 and must keep their request pending; no request is ever dropped or duplicated.
- n_rst=0 at any edge, including mid-HOLD: state=IDLE, ptr=0, out_valid=0, out_data=0, grant_id=0, busy=0. While n_rst=0, req_ready is forced to 0. A held word is discarded.

## Timing
- Latency: a request accepted at edge k appears with out_valid=1 in the cycle after edge k.
- req_ready depends combinationally on req_valid, state, ptr, out_ready and n_rst only. It never depends on req_data.
- out_valid, out_data and grant_id are registered outputs.
- Sustained throughput: one word per 2 cycles without the macro, one word per cycle with it.
- With one active requester, that requester wins every slot. With all requesters active, grants rotate 0,1,...,NUM_REQ-1,0.

## Configuration
- BUFFER_ARBITER_PIPE_EN defined: in HOLD with out_ready=1, the arbiter also grants, in the same cycle, the winner computed from ptr. On that edge the new word loads and the block stays in HOLD. If there is no request, the block goes to IDLE.
- BUFFER_ARBITER_PIPE_EN undefined: in HOLD with out_ready=1, req_ready=0 and state->IDLE. This leaves a mandatory one-cycle bubble between words.

## Structure
- Shared package buffer_arbiter_pkg holds:
  - the state enum typedef (IDLE, HOLD);
  - default constants for NUM_REQ and NUM_BITS;
  - a function for the index width.
- Sub-module rr_select: combinational, taking req_valid and ptr and producing a one-hot grant, an index and an any_valid flag. It is reused by other arbiters.
- The holding register, FSM and pointer live in the top module.

## Test plan
- Reset: hold n_rst=0 for 2 cycles with req_valid=4'b1111 -> req_ready=4'b0000, out_valid=0, out_data=0, grant_id=0. Release -> first grant goes to requester 0.
- Single request: req_valid=4'b0100, req_data[2]=32'hDEADBEEF, out_ready=1 -> req_ready=4'b0100 in cycle 0. Next cycle out_valid=1, out_data=32'hDEADBEEF, grant_id=2.
- Fairness: req_valid=4'b1111 held, out_ready=1 -> grant_id sequence 0,1,2,3,0.
  - Without the macro: a new word every 2 cycles.
  - With BUFFER_ARBITER_PIPE_EN: a new word every cycle.
- Backpressure: word held with out_ready=0 for 5 cycles while req_data changes -> out_data and grant_id constant, req_ready=4'b0000 throughout.
- Pointer wrap/skip: after a grant to 3 (ptr=0), with ptr set via a prior grant to 3 and req_valid=4'b0011 -> grants 0 then 1. Requesters 2 and 3 are skipped without stalls.
- Reset mid-HOLD: n_rst=0 for one edge while out_valid=1, out_ready=0 -> out_valid=0 and out_data=0 next cycle, ptr=0. The discarded word is not re-emitted.
